// File: rtl/calc_sequencer.sv
// Key-driven control sequencer for the calculator datapath: turns key events and
// ALU handshakes into registered load/clear strobes, mux selects and status.
`timescale 1ns/1ps
module calc_sequencer #(
  parameter int ALU_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [2:0] key_code,
  output logic       key_ready,
  output logic       alu_start,
  input  logic       alu_done,
  input  logic       alu_err,
  output logic       load_number,
  output logic       clear_number,
  output logic       load_opcode,
  output logic       clear_opcode,
  output logic       load_result,
  output logic       clear_result,
  output logic       sel_mux_alu,
  output logic       sel_mux_display,
  output logic [2:0] opcode_out,
  output logic [2:0] state_out,
  output logic       busy,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_ENTRY_A = 3'b001,
    S_OP_WAIT = 3'b010,
    S_ENTRY_B = 3'b011,
    S_EXEC    = 3'b100,
    S_SHOW    = 3'b101,
    S_ERR     = 3'b110
  } state_t;

  localparam logic [2:0]       K_NONE   = 3'b000;
  localparam logic [2:0]       K_DIGIT  = 3'b001;
  localparam logic [2:0]       K_ENTER  = 3'b010;
  localparam logic [2:0]       K_CLEAR  = 3'b011;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_opcode, w_opcode_nxt;
  logic [2:0]       r_pend_code, w_pend_code_nxt;
  logic             r_pend, w_pend_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic r_alu_start, w_alu_start_nxt;
  logic r_load_number, w_load_number_nxt;
  logic r_clear_number, w_clear_number_nxt;
  logic r_load_opcode, w_load_opcode_nxt;
  logic r_clear_opcode, w_clear_opcode_nxt;
  logic r_load_result, w_load_result_nxt;
  logic r_clear_result, w_clear_result_nxt;
  logic r_sel_mux_alu, w_sel_mux_alu_nxt;

  logic w_accept, w_is_digit, w_is_enter, w_is_clear, w_is_op;

  // No key is consumed while the ALU is running; a held key waits for the next state.
  assign w_accept   = key_valid && key_ready && (key_code != K_NONE);
  assign w_is_digit = w_accept && (key_code == K_DIGIT);
  assign w_is_enter = w_accept && (key_code == K_ENTER);
  assign w_is_clear = w_accept && (key_code == K_CLEAR);
  assign w_is_op    = w_accept && key_code[2];

  always_comb begin
    w_state_nxt        = r_state;
    w_opcode_nxt       = r_opcode;
    w_pend_nxt         = r_pend;
    w_pend_code_nxt    = r_pend_code;
    w_cnt_nxt          = (r_state == S_EXEC) ? r_cnt + CNT_W'(1) : '0;
    w_alu_start_nxt    = 1'b0;
    w_load_number_nxt  = 1'b0;
    w_clear_number_nxt = 1'b0;
    w_load_opcode_nxt  = 1'b0;
    w_clear_opcode_nxt = 1'b0;
    w_load_result_nxt  = 1'b0;
    w_clear_result_nxt = 1'b0;
    w_sel_mux_alu_nxt  = 1'b0;

    if (w_is_clear) begin
      w_clear_number_nxt = 1'b1;
      w_clear_opcode_nxt = 1'b1;
      w_clear_result_nxt = 1'b1;
      w_opcode_nxt       = 3'b000;
      w_pend_nxt         = 1'b0;
      w_state_nxt        = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_digit) begin
            w_load_number_nxt = 1'b1;
            w_state_nxt       = S_ENTRY_A;
          end
        end
        S_ENTRY_A: begin
          if (w_is_digit) begin
            w_load_number_nxt = 1'b1;
          end else if (w_is_enter) begin
            w_load_result_nxt  = 1'b1;
            w_clear_number_nxt = 1'b1;
            w_state_nxt        = S_SHOW;
          end else if (w_is_op) begin
            w_load_result_nxt  = 1'b1;
            w_clear_number_nxt = 1'b1;
            w_load_opcode_nxt  = 1'b1;
            w_opcode_nxt       = key_code;
            w_state_nxt        = S_OP_WAIT;
          end
        end
        S_OP_WAIT: begin
          if (w_is_op) begin
            w_load_opcode_nxt = 1'b1;
            w_opcode_nxt      = key_code;
          end else if (w_is_digit) begin
            w_load_number_nxt = 1'b1;
            w_state_nxt       = S_ENTRY_B;
          end
        end
        S_ENTRY_B: begin
          if (w_is_digit) begin
            w_load_number_nxt = 1'b1;
          end else if (w_is_enter || w_is_op) begin
            w_alu_start_nxt = 1'b1;
            w_pend_nxt      = w_is_op;
            w_pend_code_nxt = w_is_op ? key_code : r_pend_code;
            w_state_nxt     = S_EXEC;
          end
        end
        S_EXEC: begin
          // A done arriving on the terminal count still counts as a normal completion.
          if (alu_done && !alu_err) begin
            w_load_result_nxt  = 1'b1;
            w_sel_mux_alu_nxt  = 1'b1;
            w_clear_number_nxt = 1'b1;
            if (r_pend) begin
              w_load_opcode_nxt = 1'b1;
              w_opcode_nxt      = r_pend_code;
              w_pend_nxt        = 1'b0;
              w_state_nxt       = S_OP_WAIT;
            end else begin
              w_state_nxt = S_SHOW;
            end
          end else if (alu_done || (r_cnt == CNT_LAST)) begin
            w_state_nxt = S_ERR;
          end
        end
        S_SHOW: begin
          if (w_is_digit) begin
            w_clear_result_nxt = 1'b1;
            w_load_number_nxt  = 1'b1;
            w_state_nxt        = S_ENTRY_A;
          end else if (w_is_op) begin
            w_load_opcode_nxt = 1'b1;
            w_opcode_nxt      = key_code;
            w_state_nxt       = S_OP_WAIT;
          end
        end
        S_ERR:   ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_opcode       <= 3'b000;
      r_pend         <= 1'b0;
      r_pend_code    <= 3'b000;
      r_cnt          <= '0;
      r_alu_start    <= 1'b0;
      r_load_number  <= 1'b0;
      r_clear_number <= 1'b0;
      r_load_opcode  <= 1'b0;
      r_clear_opcode <= 1'b0;
      r_load_result  <= 1'b0;
      r_clear_result <= 1'b0;
      r_sel_mux_alu  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_opcode       <= w_opcode_nxt;
      r_pend         <= w_pend_nxt;
      r_pend_code    <= w_pend_code_nxt;
      r_cnt          <= w_cnt_nxt;
      r_alu_start    <= w_alu_start_nxt;
      r_load_number  <= w_load_number_nxt;
      r_clear_number <= w_clear_number_nxt;
      r_load_opcode  <= w_load_opcode_nxt;
      r_clear_opcode <= w_clear_opcode_nxt;
      r_load_result  <= w_load_result_nxt;
      r_clear_result <= w_clear_result_nxt;
      r_sel_mux_alu  <= w_sel_mux_alu_nxt;
    end
  end

  assign key_ready       = (r_state != S_EXEC);
  assign busy            = (r_state == S_EXEC);
  assign error           = (r_state == S_ERR);
  assign sel_mux_display = (r_state == S_OP_WAIT) || (r_state == S_EXEC) ||
                           (r_state == S_SHOW)    || (r_state == S_ERR);
  assign state_out       = r_state;
  assign opcode_out      = r_opcode;
  assign alu_start       = r_alu_start;
  assign load_number     = r_load_number;
  assign clear_number    = r_clear_number;
  assign load_opcode     = r_load_opcode;
  assign clear_opcode    = r_clear_opcode;
  assign load_result     = r_load_result;
  assign clear_result    = r_clear_result;
  assign sel_mux_alu     = r_sel_mux_alu;

endmodule
